half_inning_ctrl: RTL
=====================

// Module: half_inning_ctrl
// PURPOSE
//  Game sequencer for the baseball scoreboard: accepts one scored pitch/play event at a time,
//  maintains ball/strike/out counts, inning, half and both team scores, and drives the one-hot
//  hit[3:0] input of the base-occupancy tracker. Runs are derived from tracker occupancy.
//  Sits between the event source (keypad/ROM script) and the base tracker and display.
// PARAMETERS
//  INNINGS   9  regulation innings; extra innings are played while tied
//  SCORE_W   8  width of each score counter
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high reset
//  ev_valid     in   1        event offered
//  ev_code      in   3        0 BALL,1 STRIKE,2 FOUL,3 OUT,4 HIT1,5 HIT2,6 HIT3,7 HR
//  ev_ready     out  1        event accepted when ev_valid&&ev_ready at posedge
//  base_in      in   3        tracker occupancy {b1,b2,b3}
//  hit          out  4        to tracker: 1000 single, 0100 double, 0010 triple, 0001 HR
//  base_clear   out  1        1-cycle pulse; clears tracker at half-inning change
//  balls        out  2 / strikes out 2 / outs out 2   current count
//  inning       out  8        1-based, saturates at 255
//  half         out  1        0 top (away bats), 1 bottom (home bats)
//  score_away   out  SCORE_W / score_home out SCORE_W   saturating at all-ones
//  game_over    out  1        level; held until reset
// BEHAVIOUR
//  - Reset: state IDLE, hit=0, base_clear=0, balls=strikes=outs=0, inning=1, half=0,
//    scores=0, game_over=0. All outputs registered. Reset mid-event aborts it, no partial update.
//  - FSM: IDLE, HIT, WAIT, CHANGE, OVER. ev_ready=1 only in IDLE.
//  - IDLE, accepted BALL: balls<3 -> balls+1, stay IDLE; balls==3 -> walk: clear count,
//    go HIT with hit=1000.
//  - STRIKE: strikes<2 -> strikes+1; strikes==2 -> treated as OUT.
//  - OUT: clear count; outs<2 -> outs+1, stay IDLE; outs==2 -> go CHANGE.
//  - HITk/HR: clear count, go HIT with corresponding hit code.
//  - Non-terminal count events: accepted back-to-back every cycle.
//  - HIT (1 cycle): hit asserted exactly this cycle. Runs computed from base_in this cycle:
//    runs: single b3; double b2+b3; triple b1+b2+b3; HR b1+b2+b3+1.
//    Runs are added to the batting team (half) at the end of HIT. Then go WAIT.
//  - WAIT (1 cycle): hit=0; tracker output now updated.
//    Walk-off: half==1 && inning>=INNINGS && home>away -> OVER.
//    Otherwise -> IDLE. A hit event therefore holds ev_ready low 2 cycles.
//  - CHANGE (1 cycle): base_clear=1, outs=0, count=0.
//    half==0 -> half=1, except if inning>=INNINGS && home>away -> OVER.
//    half==1 -> if inning>=INNINGS && home!=away -> OVER, else half=0, inning+1. Next IDLE.
//  - OVER: game_over=1, ev_ready=0, all counters frozen; only reset exits.
//  - hit and base_clear are never asserted in the same cycle.
//  - Score addition saturates; inning saturates at 255.
// CONFIGURATION
//  FOUL_STRIKE_EN defined:
//    FOUL with strikes<2 -> strikes+1; with strikes==2 -> no change.
//  FOUL_STRIKE_EN undefined:
//    FOUL accepted and ignored (no state change).
//  Either way, FOUL never ends a plate appearance.
// TESTING
//  - Reset, then 4x BALL on empty bases -> hit=1000 for 1 cycle, balls=0, ev_ready low 2 cycles,
//    score unchanged.
//  - Tracker at {1,1,1}, top 1st: accept HR -> score_away+=4 visible in WAIT; hit=0001 for
//    exactly 1 cycle.
//  - 3x OUT in top 1st -> base_clear pulse 1 cycle, outs=0, half=1, inning=1;
//    3 more OUTs -> half=0, inning=2.
//  - Bottom 9th, away 2 home 2, tracker {0,0,1}: HIT1 -> home=3, game_over=1, ev_ready stays 0.
//  - End of top 9th with home 1 away 0 -> OVER without bottom half.
//  - End of 9th tied -> inning=10 continues.
//  - STRIKE, STRIKE, FOUL, STRIKE -> OUT.
//    FOUL_STRIKE_EN: STRIKE, FOUL, FOUL, STRIKE -> outs+1.
//    Without FOUL_STRIKE_EN: the same sequence -> strikes=2.

Source files
------------

// File: rtl/half_inning_ctrl_if.sv
// -----------------------------------------------------------------------------
// half_inning_ctrl_if
// Event handshake between the play-event source (keypad / ROM script) and the
// half-inning sequencer.
//   ev_valid  source -> sequencer  event offered
//   ev_code   source -> sequencer  0 BALL,1 STRIKE,2 FOUL,3 OUT,4 HIT1,5 HIT2,6 HIT3,7 HR
//   ev_ready  sequencer -> source  event taken when ev_valid && ev_ready at posedge
// -----------------------------------------------------------------------------
interface half_inning_ctrl_if;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/half_inning_ctrl.sv
// -----------------------------------------------------------------------------
// half_inning_ctrl
// Baseball game sequencer. Takes one play event at a time, keeps the
// ball/strike/out count, inning, half and both scores, and drives the one-hot
// hit code into the base-occupancy tracker. Runs come from tracker occupancy.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ev (slave)          event handshake (ev_valid, ev_code, ev_ready)
//   base_in[2:0]        tracker occupancy {b1,b2,b3}
//   hit[3:0]            1000 single, 0100 double, 0010 triple, 0001 HR (1 cycle)
//   base_clear          1-cycle pulse clearing the tracker at half-inning change
//   balls/strikes/outs  current count
//   inning              1-based, saturates at 255
//   half                0 top (away bats), 1 bottom (home bats)
//   score_away/home     saturating scores
//   game_over           level, held until reset
//
// Build option: FOUL_STRIKE_EN -- when defined a FOUL counts as a strike
// below two strikes; when undefined a FOUL is accepted and ignored.
// -----------------------------------------------------------------------------
module half_inning_ctrl #(
  parameter int INNINGS = 9,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  half_inning_ctrl_if.slave  ev,
  input  logic [2:0]         base_in,
  output logic [3:0]         hit,
  output logic               base_clear,
  output logic [1:0]         balls,
  output logic [1:0]         strikes,
  output logic [1:0]         outs,
  output logic [7:0]         inning,
  output logic               half,
  output logic [SCORE_W-1:0] score_away,
  output logic [SCORE_W-1:0] score_home,
  output logic               game_over
);

  localparam logic [2:0] EV_BALL   = 3'd0;
  localparam logic [2:0] EV_STRIKE = 3'd1;
  localparam logic [2:0] EV_FOUL   = 3'd2;
  localparam logic [2:0] EV_OUT    = 3'd3;
  localparam logic [2:0] EV_HIT1   = 3'd4;
  localparam logic [2:0] EV_HIT2   = 3'd5;
  localparam logic [2:0] EV_HIT3   = 3'd6;
  localparam logic [2:0] EV_HR     = 3'd7;
  localparam logic [7:0] INN_L     = 8'(INNINGS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HIT    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         hit_q, hit_d;
  logic               base_clear_q, base_clear_d;
  logic               ev_ready_q, ev_ready_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         balls_q, balls_d, strikes_q, strikes_d, outs_q, outs_d;
  logic [7:0]         inning_q, inning_d;
  logic               half_q, half_d;
  logic [SCORE_W-1:0] away_q, away_d, home_q, home_d;
  logic [2:0]         runs_s;
  logic               do_out_s;
  logic               late_s;

  // Runs scored by a hit given occupancy {b1,b2,b3} before the tracker advances.
  function automatic logic [2:0] calc_runs(input logic [3:0] h, input logic [2:0] b);
    logic [2:0] r;
    r = 3'd0;
    case (h)
      4'b1000: r = {2'b00, b[0]};
      4'b0100: r = {2'b00, b[1]} + {2'b00, b[0]};
      4'b0010: r = {2'b00, b[2]} + {2'b00, b[1]} + {2'b00, b[0]};
      4'b0001: r = {2'b00, b[2]} + {2'b00, b[1]} + {2'b00, b[0]} + 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Score + runs, clamped at all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [2:0] r);
    logic [SCORE_W:0] t;
    t = {1'b0, s} + {{(SCORE_W-2){1'b0}}, r};
    if (t[SCORE_W]) begin
      return {SCORE_W{1'b1}};
    end else begin
      return t[SCORE_W-1:0];
    end
  endfunction

  assign late_s      = (inning_q >= INN_L);
  assign runs_s      = calc_runs(hit_q, base_in);
  assign ev.ev_ready = ev_ready_q;
  assign hit         = hit_q;
  assign base_clear  = base_clear_q;
  assign balls       = balls_q;
  assign strikes     = strikes_q;
  assign outs        = outs_q;
  assign inning      = inning_q;
  assign half        = half_q;
  assign score_away  = away_q;
  assign score_home  = home_q;
  assign game_over   = game_over_q;

  // Next-state and next-output logic for the game sequencer.
  always_comb begin
    state_d   = state_q;
    hit_d     = 4'b0000;
    balls_d   = balls_q;
    strikes_d = strikes_q;
    outs_d    = outs_q;
    inning_d  = inning_q;
    half_d    = half_q;
    away_d    = away_q;
    home_d    = home_q;
    do_out_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev.ev_valid) begin
          case (ev.ev_code)
            EV_BALL: begin
              if (balls_q == 2'd3) begin
                balls_d   = 2'd0;
                strikes_d = 2'd0;
                hit_d     = 4'b1000;
                state_d   = ST_HIT;
              end else begin
                balls_d = balls_q + 2'd1;
              end
            end
            EV_STRIKE: begin
              if (strikes_q == 2'd2) begin
                do_out_s = 1'b1;
              end else begin
                strikes_d = strikes_q + 2'd1;
              end
            end
            EV_FOUL: begin
`ifdef FOUL_STRIKE_EN
              if (strikes_q != 2'd2) begin
                strikes_d = strikes_q + 2'd1;
              end else begin
                strikes_d = strikes_q;
              end
`else
              strikes_d = strikes_q;
`endif
            end
            EV_OUT: do_out_s = 1'b1;
            EV_HIT1, EV_HIT2, EV_HIT3, EV_HR: begin
              balls_d   = 2'd0;
              strikes_d = 2'd0;
              hit_d     = 4'b1000 >> (ev.ev_code - EV_HIT1);
              state_d   = ST_HIT;
            end
            default: state_d = state_q;
          endcase
          // Outs clear the count; the third out also clears outs on entry to CHANGE.
          if (do_out_s) begin
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            if (outs_q == 2'd2) begin
              outs_d  = 2'd0;
              state_d = ST_CHANGE;
            end else begin
              outs_d = outs_q + 2'd1;
            end
          end else begin
            outs_d = outs_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HIT: begin
        if (half_q) begin
          home_d = sat_add(home_q, runs_s);
        end else begin
          away_d = sat_add(away_q, runs_s);
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (half_q && late_s && (home_q > away_q)) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        state_d = ST_IDLE;
        if (!half_q) begin
          if (late_s && (home_q > away_q)) begin
            state_d = ST_OVER;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          if (late_s && (home_q != away_q)) begin
            state_d = ST_OVER;
          end else begin
            half_d   = 1'b0;
            inning_d = (inning_q == 8'd255) ? inning_q : inning_q + 8'd1;
          end
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase

    base_clear_d = (state_d == ST_CHANGE);
    ev_ready_d   = (state_d == ST_IDLE);
    game_over_d  = (state_d == ST_OVER);
  end

  // State and registered outputs; reset aborts any in-flight event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hit_q        <= 4'b0000;
      base_clear_q <= 1'b0;
      ev_ready_q   <= 1'b1;
      game_over_q  <= 1'b0;
      balls_q      <= 2'd0;
      strikes_q    <= 2'd0;
      outs_q       <= 2'd0;
      inning_q     <= 8'd1;
      half_q       <= 1'b0;
      away_q       <= {SCORE_W{1'b0}};
      home_q       <= {SCORE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_d;
      base_clear_q <= base_clear_d;
      ev_ready_q   <= ev_ready_d;
      game_over_q  <= game_over_d;
      balls_q      <= balls_d;
      strikes_q    <= strikes_d;
      outs_q       <= outs_d;
      inning_q     <= inning_d;
      half_q       <= half_d;
      away_q       <= away_d;
      home_q       <= home_d;
    end
  end

endmodule
